// File: rtl/axis_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pkg
//  Purpose  : Shared AXI4-Stream word definitions for the arbiter / FIFO path.
//  Revision : 1.0  initial release
// ============================================================================
package axis_pkg;

    localparam int AXIS_DATA_W = 32;

    // One stream beat as stored in buffers: tlast travels with its data.
    typedef struct packed {
        logic                   tlast;
        logic [AXIS_DATA_W-1:0] tdata;
    } axis_word_t;

endpackage : axis_pkg
`default_nettype wire

// File: rtl/axis_sdp_ram.sv
`default_nettype none
// ============================================================================
//  Module   : axis_sdp_ram
//  Purpose  : Simple dual-port word RAM, one write port and one registered
//             read port, shaped for block-RAM inference.
//  Revision : 1.0  initial release
// ============================================================================
module axis_sdp_ram
    import axis_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  axis_word_t        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output axis_word_t        rd_data
);

    axis_word_t r_mem [DEPTH];
    axis_word_t r_rd_data;

    // Write port: no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Registered read port: output holds until the next enabled read.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule : axis_sdp_ram
`default_nettype wire

// File: rtl/axis_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : axis_packet_fifo
//  Purpose  : Store-and-forward AXI4-Stream packet FIFO. A packet is shown
//             to the consumer only once complete, except for oversize
//             packets which are force-released when the buffer fills.
//  Revision : 1.0  initial release
// ============================================================================
module axis_packet_fifo
    import axis_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [AXIS_DATA_W-1:0] m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [ADDR_W:0]        level,
    output logic [ADDR_W:0]        pkt_count,
    output logic                   overflow_release
);

    localparam logic [ADDR_W:0]   LVL_ZERO = '0;
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

    // Words flow RAM -> prefetch stage -> output register. The prefetch
    // stage is either the RAM read register or a bypass copy of a word
    // written while the RAM had nothing else waiting, so a freshly completed
    // packet reaches the output one edge after its tlast is accepted.
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [ADDR_W:0]   r_pkt_count;
    logic              r_pf_valid;
    logic              r_pf_byp;
    axis_word_t        r_byp_word;
    logic              r_out_valid;
    axis_word_t        r_out_word;
    logic              r_in_pkt;
    logic              r_overflow;

    axis_word_t        w_in_word;
    axis_word_t        w_ram_q;
    axis_word_t        w_pf_word;
    logic              w_wr;
    logic              w_del;
    logic [ADDR_W:0]   w_unfetched;
    logic [ADDR_W:0]   w_pend_pkts;
    logic              w_full;
    logic              w_release;
    logic              w_load_out;
    logic              w_pf_free;
    logic              w_ram_rd;
    logic              w_byp;
    logic              w_fetch;
    logic              w_forced;

    assign w_in_word   = '{tlast: s_axis_tlast, tdata: s_axis_tdata};
    assign w_full      = (r_level == LVL_FULL);
    assign w_wr        = s_axis_tvalid & s_axis_tready;
    assign w_del       = r_out_valid & m_axis_tready;
    assign w_pf_word   = r_pf_byp ? r_byp_word : w_ram_q;

    // Words sitting in RAM that have not moved into a pipeline stage.
    assign w_unfetched = r_level - (ADDR_W+1)'(r_pf_valid) - (ADDR_W+1)'(r_out_valid);

    // Complete packets not yet started on the output; a tlast word already
    // in the output register belongs to a packet that has been launched.
    assign w_pend_pkts = r_pkt_count - (ADDR_W+1)'(r_out_valid & r_out_word.tlast);

    // Mid-packet keeps the grant; at a packet boundary start only a complete
    // packet, or an oversize one once the buffer is full.
    assign w_release   = r_in_pkt | (w_pend_pkts != LVL_ZERO) | w_full;
    assign w_forced    = ~r_in_pkt & (w_pend_pkts == LVL_ZERO) & w_full;
    assign w_load_out  = r_pf_valid & w_release & (~r_out_valid | w_del);
    assign w_pf_free   = ~r_pf_valid | w_load_out;
    assign w_ram_rd    = w_pf_free & (w_unfetched != LVL_ZERO);
    assign w_byp       = w_pf_free & (w_unfetched == LVL_ZERO) & w_wr;
    assign w_fetch     = w_ram_rd | w_byp;

    axis_sdp_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (axis_aclk),
        .wr_en   (w_wr),
        .wr_addr (r_wr_ptr),
        .wr_data (w_in_word),
        .rd_en   (w_ram_rd),
        .rd_addr (r_rd_ptr),
        .rd_data (w_ram_q)
    );

    // Pointers, occupancy counters, pipeline valid flags and release state.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_pkt_count <= '0;
            r_pf_valid  <= 1'b0;
            r_pf_byp    <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_pkt    <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_fetch) begin
                r_rd_ptr   <= r_rd_ptr + PTR_ONE;
                r_pf_valid <= 1'b1;
                r_pf_byp   <= w_byp;
            end else if (w_load_out) begin
                r_pf_valid <= 1'b0;
            end
            case ({w_wr, w_del})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            case ({w_wr & s_axis_tlast, w_del & r_out_word.tlast})
                2'b10:   r_pkt_count <= r_pkt_count + LVL_ONE;
                2'b01:   r_pkt_count <= r_pkt_count - LVL_ONE;
                default: r_pkt_count <= r_pkt_count;
            endcase
            if (w_load_out) begin
                r_out_valid <= 1'b1;
                r_in_pkt    <= ~w_pf_word.tlast;
            end else if (w_del) begin
                r_out_valid <= 1'b0;
            end
            if (w_load_out & w_forced) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Data registers: bypass copy of an incoming word and the output word.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_byp_word <= '0;
            r_out_word <= '0;
        end else begin
            if (w_byp) begin
                r_byp_word <= w_in_word;
            end
            if (w_load_out) begin
                r_out_word <= w_pf_word;
            end
        end
    end

    assign s_axis_tready    = (r_level < LVL_FULL);
    assign m_axis_tdata     = r_out_word.tdata;
    assign m_axis_tlast     = r_out_word.tlast;
    assign m_axis_tvalid    = r_out_valid;
    assign level            = r_level;
    assign pkt_count        = r_pkt_count;
    assign overflow_release = r_overflow;

endmodule : axis_packet_fifo
`default_nettype wire
